// File: rtl/leaf_index_queue_if.sv
// Bundle of the leaf_index_queue input streams, drain handshake and status.
// The master modport is the side that feeds leaves and consumes entries;
// the slave modport is the queue itself.
// Optional statistics signals exist only when LEAF_QUEUE_STATS_EN is defined.
interface leaf_index_queue_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int QUERY_WIDTH   = 10,
    parameter int DEPTH         = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     clear;
    logic                     in_en;
    logic [ADDRESS_WIDTH-1:0] in_leaf;
    logic                     in_two_en;
    logic [ADDRESS_WIDTH-1:0] in_leaf_two;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDRESS_WIDTH-1:0] out_leaf;
    logic                     out_stream;
    logic [QUERY_WIDTH-1:0]   out_query;
    logic [CW-1:0]            count;
    logic                     almost_full;
    logic                     overflow;
`ifdef LEAF_QUEUE_STATS_EN
    logic [CW-1:0]            stat_max_count;
    logic [15:0]              stat_drop_count;
`endif

    modport master (
        output clear, in_en, in_leaf, in_two_en, in_leaf_two, out_ready,
        input  out_valid, out_leaf, out_stream, out_query, count, almost_full, overflow
`ifdef LEAF_QUEUE_STATS_EN
        , input stat_max_count, stat_drop_count
`endif
    );

    modport slave (
        input  clear, in_en, in_leaf, in_two_en, in_leaf_two, out_ready,
        output out_valid, out_leaf, out_stream, out_query, count, almost_full, overflow
`ifdef LEAF_QUEUE_STATS_EN
        , output stat_max_count, stat_drop_count
`endif
    );
endinterface

// File: rtl/leaf_index_queue.sv
// leaf_index_queue: merges the two KD-tree leaf-index streams into one FIFO.
// Every entry is tagged with its stream bit and a per-stream query number so
// the k-NN compare stage can detect lost queries as gaps in the numbering.
// The traversal pipeline cannot stall: entries that do not fit are dropped
// and recorded in the sticky overflow flag; almost_full is for throttling.
// Optional build macro LEAF_QUEUE_STATS_EN adds a count high-water mark and
// a saturating dropped-entry counter.
//
// Drain handshake: out_valid is high whenever the FIFO holds an entry; the
// head entry is transferred on a cycle where out_valid and out_ready are
// both high. While out_valid is high and out_ready is low, the head fields
// are held stable. out_valid never depends on out_ready.
module leaf_index_queue #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int QUERY_WIDTH   = 10,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    leaf_index_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage, split per field; slots are addressed by the pointers.
    logic [ADDRESS_WIDTH-1:0] leaf_mem_q   [DEPTH];
    logic                     stream_mem_q [DEPTH];
    logic [QUERY_WIDTH-1:0]   query_mem_q  [DEPTH];

    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [QUERY_WIDTH-1:0] qry0_q, qry0_d;
    logic [QUERY_WIDTH-1:0] qry1_q, qry1_d;
    logic                   overflow_q, overflow_d;

    logic                   head_valid;
    logic                   pop;
    logic [CW:0]            free_slots;
    logic [CW:0]            need_two;
    logic                   wr0;
    logic                   wr1;
    logic [PW-1:0]          slot0;
    logic [PW-1:0]          slot1;
    logic [1:0]             n_drop;

    // Space arbitration: credit the same-cycle pop, stream 0 has first claim.
    always_comb begin
        head_valid = (count_q != '0);
        pop        = head_valid & bus.out_ready;
        free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
        need_two   = bus.in_en ? (CW+1)'(2) : (CW+1)'(1);
        wr0        = bus.in_en & (free_slots != '0);
        wr1        = bus.in_two_en & (free_slots >= need_two);
        slot0      = wr_ptr_q;
        slot1      = wr_ptr_q + PW'(wr0);
        n_drop     = {1'b0, bus.in_en & ~wr0} + {1'b0, bus.in_two_en & ~wr1};
    end

    // Next-state for pointers, occupancy, query counters and overflow.
    // clear wins over everything, including same-cycle writes and pops.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(wr0) + PW'(wr1);
        count_d    = count_q + CW'(wr0) + CW'(wr1) - CW'(pop);
        qry0_d     = qry0_q + QUERY_WIDTH'(bus.in_en);
        qry1_d     = qry1_q + QUERY_WIDTH'(bus.in_two_en);
        overflow_d = overflow_q | (n_drop != 2'd0);
        if (bus.clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            qry0_d     = '0;
            qry1_d     = '0;
            overflow_d = 1'b0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            qry0_q     <= '0;
            qry1_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            qry0_q     <= qry0_d;
            qry1_q     <= qry1_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry writes; storage needs no reset because empty slots are never shown.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.clear) begin
            if (wr0) begin
                leaf_mem_q[slot0]   <= bus.in_leaf;
                stream_mem_q[slot0] <= 1'b0;
                query_mem_q[slot0]  <= qry0_q;
            end
            if (wr1) begin
                leaf_mem_q[slot1]   <= bus.in_leaf_two;
                stream_mem_q[slot1] <= 1'b1;
                query_mem_q[slot1]  <= qry1_q;
            end
        end
    end

    // Head read straight from the head slot; forced to zero while empty.
    always_comb begin
        bus.out_valid   = head_valid;
        bus.out_leaf    = '0;
        bus.out_stream  = 1'b0;
        bus.out_query   = '0;
        if (head_valid) begin
            bus.out_leaf   = leaf_mem_q[rd_ptr_q];
            bus.out_stream = stream_mem_q[rd_ptr_q];
            bus.out_query  = query_mem_q[rd_ptr_q];
        end
        bus.count       = count_q;
        bus.almost_full = (count_q >= CW'(AFULL_THRESH));
        bus.overflow    = overflow_q;
    end

`ifdef LEAF_QUEUE_STATS_EN
    logic [CW-1:0] stat_max_q;
    logic [CW-1:0] stat_max_d;
    logic [15:0]   stat_drop_q;
    logic [15:0]   stat_drop_d;
    logic [16:0]   drop_sum;

    // High-water mark follows the registered occupancy; drops saturate.
    always_comb begin
        stat_max_d  = (count_d > stat_max_q) ? count_d : stat_max_q;
        drop_sum    = {1'b0, stat_drop_q} + 17'(n_drop);
        stat_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (bus.clear) begin
            stat_max_d  = '0;
            stat_drop_d = '0;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_max_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_max_q  <= stat_max_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    // Statistics outputs.
    always_comb begin
        bus.stat_max_count  = stat_max_q;
        bus.stat_drop_count = stat_drop_q;
    end
`endif

endmodule
